// File: rtl/ddr_tx_serializer.sv
// Transmit serialiser: buffers parallel words in a small FIFO and emits two bits per clock
// as registered D0/D1 for an output-DDR primitive. Optional macro: DDR_TX_LSB_FIRST_EN.
module ddr_tx_serializer #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic        INIT_D0    = 1'b0,
    parameter logic        INIT_D1    = 1'b0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [WORD_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          out_d0,
    output logic                          out_d1,
    output logic                          out_ce,
    output logic                          out_oe,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy
);

    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW  = PtrW + 1;
    localparam int unsigned Beats = WORD_WIDTH / 2;
    localparam int unsigned CntW  = (Beats > 1) ? $clog2(Beats) : 1;

    localparam logic [LvlW-1:0] FullLvl  = LvlW'(FIFO_DEPTH);
    localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q, state_d;

    logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]       level_q, level_d;

    logic [WORD_WIDTH-1:0] sr_q, sr_d;
    logic [CntW-1:0]       cnt_q, cnt_d;

    logic                  out_d0_q, out_d0_d;
    logic                  out_d1_q, out_d1_d;
    logic                  out_ce_q, out_ce_d;
    logic                  out_oe_q, out_oe_d;

    logic                  push;
    logic                  pop;
    logic                  fifo_empty;
    logic                  last_beat;

    // ------------------------------------------------------------------
    // FIFO control
    // ------------------------------------------------------------------
    assign in_ready   = (level_q != FullLvl);
    assign fifo_empty = (level_q == '0);
    assign push       = in_valid && in_ready;
    assign last_beat  = (cnt_q == LastBeat);

    // A word is pulled into the shifter from idle, or back-to-back on the last beat.
    assign pop = !fifo_empty && ((state_q == StIdle) || last_beat);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: pointers and level define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (last_beat && fifo_empty) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next values of the registered pad-side signals)
    // ------------------------------------------------------------------
    always_comb begin
        out_d0_d = INIT_D0;
        out_d1_d = INIT_D1;
        out_ce_d = 1'b0;
        out_oe_d = 1'b0;
        if (state_q == StShift) begin
            out_ce_d = 1'b1;
            out_oe_d = 1'b1;
`ifdef DDR_TX_LSB_FIRST_EN
            out_d0_d = sr_q[0];
            out_d1_d = sr_q[1];
`else
            out_d0_d = sr_q[WORD_WIDTH-1];
            out_d1_d = sr_q[WORD_WIDTH-2];
`endif
        end
    end

    // ------------------------------------------------------------------
    // Shifter and beat counter
    // ------------------------------------------------------------------
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (pop) begin
            sr_d  = mem_q[rd_ptr_q];
            cnt_d = '0;
        end else if (state_q == StShift) begin
`ifdef DDR_TX_LSB_FIRST_EN
            sr_d = sr_q >> 2;
`else
            sr_d = sr_q << 2;
`endif
            cnt_d = last_beat ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            out_d0_q <= INIT_D0;
            out_d1_q <= INIT_D1;
            out_ce_q <= 1'b0;
            out_oe_q <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            out_d0_q <= out_d0_d;
            out_d1_q <= out_d1_d;
            out_ce_q <= out_ce_d;
            out_oe_q <= out_oe_d;
        end
    end

    assign out_d0     = out_d0_q;
    assign out_d1     = out_d1_q;
    assign out_ce     = out_ce_q;
    assign out_oe     = out_oe_q;
    assign fifo_level = level_q;
    assign busy       = (state_q == StShift) || !fifo_empty;

endmodule
